// File: rtl/rr_arbiter_reg.sv
// rr_arbiter_reg: N-way round-robin arbiter feeding a single-entry output register.
// One requester is selected per cycle, starting the search at the priority
// pointer. Its payload is captured into the output buffer, and the pointer
// rotates past the winner after each accepted transfer.
// Optional build macro RR_ARB_PRIO0_EN: requester 0 gets absolute priority,
// and a grant to it does not move the pointer.
module rr_arbiter_reg #(
  parameter  int N      = 4,
  parameter  int DATA_W = 64,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic [N-1:0]        valid_i,
  input  logic [N*DATA_W-1:0] data_i,
  output logic [N-1:0]        ready_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_W-1:0]   data_o,
  output logic [IDX_W-1:0]    grant_idx_o
);

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic [IDX_W:0]    cand;
  logic              cand_ok;
  logic              can_accept;
  logic              xfer_in;
  logic              adv_ptr;
  logic [IDX_W-1:0]  ptr_next;
  logic [DATA_W-1:0] sel_data;

  // Buffer may take a new payload when it is empty or draining this cycle.
  assign can_accept = !valid_o || ready_i;
  assign xfer_in    = win_found && can_accept && !flush_i;

  // Explicit wrap so non-power-of-two N still rotates correctly.
  assign ptr_next = (win_idx == IDX_W'(N-1)) ? '0 : win_idx + 1'b1;

`ifdef RR_ARB_PRIO0_EN
  // The high-priority requester is served out of band and leaves the rotation alone.
  assign adv_ptr = (win_idx != '0);
`else
  assign adv_ptr = 1'b1;
`endif

  // Find the first valid requester at or after ptr, wrapping past N-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_ok   = 1'b0;
`ifdef RR_ARB_PRIO0_EN
    if (valid_i[0]) win_found = 1'b1;
`endif
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
`ifdef RR_ARB_PRIO0_EN
      cand_ok = (cand != '0);
`else
      cand_ok = 1'b1;
`endif
      if (!win_found && cand_ok && valid_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Grant only the winner, and only when the transfer can actually land.
  always_comb begin
    ready_o = '0;
    if (xfer_in) ready_o[win_idx] = 1'b1;
  end

  // Payload mux for the winning requester.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (win_idx == IDX_W'(k)) sel_data = data_i[k*DATA_W +: DATA_W];
    end
  end

  // Output buffer and priority pointer; flush outranks every other event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o     <= 1'b0;
      data_o      <= '0;
      grant_idx_o <= '0;
      ptr         <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (xfer_in) begin
      valid_o     <= 1'b1;
      data_o      <= sel_data;
      grant_idx_o <= win_idx;
      if (adv_ptr) ptr <= ptr_next;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_reg.sv
// Bench for rr_arbiter_reg.
// The stimulus process predicts each grant from the arbitration rules and
// queues the expected payload. A negedge monitor pops and compares the queue
// whenever the DUT hands a payload downstream.
module tb_rr_arbiter_reg;
  localparam int N      = 4;
  localparam int DATA_W = 64;
  localparam int IDX_W  = $clog2(N);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } exp_item_t;

  logic                clk_i = 1'b0;
  logic                rst_n_i = 1'b0;
  logic                flush_i = 1'b0;
  logic [N-1:0]        valid_i = '0;
  logic [N*DATA_W-1:0] data_i = '0;
  logic [N-1:0]        ready_o;
  logic                valid_o;
  logic                ready_i = 1'b0;
  logic [DATA_W-1:0]   data_o;
  logic [IDX_W-1:0]    grant_idx_o;

  int        tests = 0;
  int        fails = 0;
  exp_item_t sb_q[$];
  exp_item_t mon_e;
  int        ptr_m = 0;
  bit        full_m = 1'b0;
  bit        rand_data = 1'b1;

  rr_arbiter_reg #(.N(N), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .grant_idx_o(grant_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every downstream handshake must deliver the oldest predicted payload.
  always @(negedge clk_i) begin
    if (rst_n_i && valid_o && ready_i && !flush_i) begin
      if (sb_q.size() == 0) begin
        check(sb_q.size() != 0, "sb_underflow", 0, 1);
      end else begin
        mon_e = sb_q.pop_front();
        check(grant_idx_o == mon_e.idx, "grant_idx_o", grant_idx_o, mon_e.idx);
        check(data_o == mon_e.data, "data_o", data_o, mon_e.data);
      end
    end
  end

  // Winner from the rules: scan ptr, ptr+1, ... mod N; requester 0 first in prio builds.
  function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef RR_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
`ifdef RR_ARB_PRIO0_EN
      if (idx == 0) continue;
`endif
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic rdy, input logic fl);
    int win;
    bit xfer;
    logic [N-1:0] exp_ready;
    exp_item_t e;
    @(posedge clk_i);
    #1;
    valid_i = v;
    ready_i = rdy;
    flush_i = fl;
    for (int k = 0; k < N; k++)
      data_i[k*DATA_W +: DATA_W] = rand_data ? {$urandom, $urandom} : 64'hA4 + 64'(k);
    #1;
    win  = pick(v, ptr_m);
    xfer = (win >= 0) && (!full_m || rdy) && !fl;
    exp_ready = '0;
    if (xfer) exp_ready[win] = 1'b1;
    check(ready_o == exp_ready, "ready_o", 64'(ready_o), 64'(exp_ready));
    check(valid_o == full_m, "valid_o", 64'(valid_o), 64'(full_m));
    if (fl) begin
      if (full_m) void'(sb_q.pop_back());
      full_m = 1'b0;
    end else if (xfer) begin
      e.idx  = IDX_W'(win);
      e.data = data_i[win*DATA_W +: DATA_W];
      sb_q.push_back(e);
      full_m = 1'b1;
`ifdef RR_ARB_PRIO0_EN
      if (win != 0) ptr_m = (win + 1) % N;
`else
      ptr_m = (win + 1) % N;
`endif
    end else if (rdy) begin
      full_m = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(valid_o == 1'b0, {tag, "_valid_o"}, 64'(valid_o), 0);
    check(data_o == '0, {tag, "_data_o"}, data_o, 0);
    check(grant_idx_o == '0, {tag, "_grant_idx_o"}, 64'(grant_idx_o), 0);
  endtask

  initial begin
    #1;
    check_reset_outputs("por");
    #22 rst_n_i = 1'b1;

    // Lowest valid index wins straight after reset.
    step(4'b0110, 1'b1, 1'b0);
    // Full rotation with everyone requesting.
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0);

    // Asynchronous reset while the buffer holds a payload.
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    valid_i = '0;
    ready_i = 1'b0;
    #1 check_reset_outputs("mid_rst");
    sb_q.delete();
    full_m = 1'b0;
    ptr_m  = 0;
    #9 rst_n_i = 1'b1;

    // Backpressure: requester 1 payload 0xA5 held while the consumer stalls.
    rand_data = 1'b0;
    step(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      check(data_o == 64'hA5, "stall_data_o", data_o, 64'hA5);
    end
    step(4'b1111, 1'b1, 1'b0);
    rand_data = 1'b1;

    // Wrap from ptr 3 to requester 0, then on to requester 2.
    step(4'b0101, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b0);

    // Flush while stalled; pointer must survive it.
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);

    // Requester 0 held then dropped (absolute priority in prio builds).
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b1110, 1'b1, 1'b0);

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 1500; i++)
      step(N'($urandom_range(0, (1 << N) - 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));

    // Drain and confirm nothing predicted was left undelivered.
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    @(negedge clk_i);
    #1;
    check(sb_q.size() == 0, "sb_leftover", 64'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
